ram_fifo_ctrl: RTL and testbench

Circular-buffer controller that sits directly upstream of and around the 32x48 dual-port RAM. It turns the RAM into a valid/ready FIFO. Port A is the write port and is driven from an input stream. Port B is read-only and feeds a registered output stream. An optional preload count lets the words loaded into the RAM at initialisation be drained as if they had already been written.

---
 rtl/ram_fifo_ctrl.sv | 95 +++++++++
 tb/tb_ram_fifo_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// Valid/ready FIFO controller wrapped around a dual-port RAM.
// Port A writes the input stream, port B feeds a registered output stage.
module ram_fifo_ctrl #(
   parameter int WIDTH      = 32,
   parameter int HEIGHT     = 48,
   parameter int INIT_COUNT = 0,
   localparam int AW        = $clog2(HEIGHT) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [AW-1:0]    ram_addr_a,
   output logic [WIDTH-1:0] ram_data_a,
   output logic             ram_we_a,
   output logic [AW-1:0]    ram_addr_b,
   output logic [WIDTH-1:0] ram_data_b,
   output logic             ram_we_b,
   input  logic [WIDTH-1:0] ram_q_b,
   output logic [AW-1:0]    count,
   output logic             full,
   output logic             empty
);

   localparam logic [AW-1:0] ONE     = AW'(1);
   localparam logic [AW-1:0] LAST    = AW'(HEIGHT - 1);
   localparam logic [AW-1:0] DEPTH   = AW'(HEIGHT);
   localparam logic [AW-1:0] CNT_RST = AW'(INIT_COUNT);
   localparam logic [AW-1:0] WR_RST  =
      (INIT_COUNT == HEIGHT) ? '0 : AW'(INIT_COUNT);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] mem_count;
   logic          push;
   logic          load;

   // Depth need not be a power of two, so wrap explicitly.
   function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
      return (p == LAST) ? '0 : p + ONE;
   endfunction

   assign full     = (mem_count == DEPTH);
   assign in_ready = !full && !flush && !rst;
   assign push     = in_valid && in_ready;
   assign load     = (!out_valid || out_ready)
                   && (mem_count != '0) && !flush;

   assign ram_we_a   = push;
   assign ram_addr_a = wr_ptr;
   assign ram_data_a = in_data;
   assign ram_addr_b = rd_ptr;
   assign ram_data_b = '0;
   assign ram_we_b   = 1'b0;

   assign count = mem_count + {{(AW-1){1'b0}}, out_valid};
   assign empty = (count == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= WR_RST;
         rd_ptr    <= '0;
         mem_count <= CNT_RST;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         mem_count <= '0;
         out_valid <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= inc(wr_ptr);
         end
         if (load) begin
            out_data  <= ram_q_b;
            out_valid <= 1'b1;
            rd_ptr    <= inc(rd_ptr);
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (push && !load) begin
            mem_count <= mem_count + ONE;
         end else if (load && !push) begin
            mem_count <= mem_count - ONE;
         end
      end
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with behavioural RAMs on both instances.
// u0 has no preload, u1 is preloaded with five words.
module tb_ram_fifo_ctrl;

   localparam int W  = 32;
   localparam int H  = 48;
   localparam int AW = 7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic          rst, flush, in_valid, out_ready;
   logic [W-1:0]  in_data, out_data, ram_data_a, ram_data_b, ram_q_b;
   logic          in_ready, out_valid, ram_we_a, ram_we_b;
   logic          full, empty;
   logic [AW-1:0] ram_addr_a, ram_addr_b, count;
   logic [W-1:0]  mem0 [H];

   logic          rst_1, flush_1, in_valid_1, out_ready_1;
   logic [W-1:0]  in_data_1, out_data_1, ram_data_a_1, ram_data_b_1;
   logic [W-1:0]  ram_q_b_1;
   logic          in_ready_1, out_valid_1, ram_we_a_1, ram_we_b_1;
   logic          full_1, empty_1;
   logic [AW-1:0] ram_addr_a_1, ram_addr_b_1, count_1;
   logic [W-1:0]  mem1 [H];
   logic          pl_we;
   logic [AW-1:0] pl_addr;
   logic [W-1:0]  pl_data;

   always @(posedge clk) if (ram_we_a) mem0[ram_addr_a] <= ram_data_a;
   assign ram_q_b = mem0[ram_addr_b];

   always @(posedge clk) begin
      if (ram_we_a_1) mem1[ram_addr_a_1] <= ram_data_a_1;
      else if (pl_we) mem1[pl_addr] <= pl_data;
   end
   assign ram_q_b_1 = mem1[ram_addr_b_1];

   ram_fifo_ctrl #(.WIDTH(W), .HEIGHT(H), .INIT_COUNT(0)) u0 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .ram_addr_a(ram_addr_a), .ram_data_a(ram_data_a),
      .ram_we_a(ram_we_a), .ram_addr_b(ram_addr_b),
      .ram_data_b(ram_data_b), .ram_we_b(ram_we_b), .ram_q_b(ram_q_b),
      .count(count), .full(full), .empty(empty)
   );

   ram_fifo_ctrl #(.WIDTH(W), .HEIGHT(H), .INIT_COUNT(5)) u1 (
      .clk(clk), .rst(rst_1), .flush(flush_1),
      .in_data(in_data_1), .in_valid(in_valid_1), .in_ready(in_ready_1),
      .out_data(out_data_1), .out_valid(out_valid_1),
      .out_ready(out_ready_1),
      .ram_addr_a(ram_addr_a_1), .ram_data_a(ram_data_a_1),
      .ram_we_a(ram_we_a_1), .ram_addr_b(ram_addr_b_1),
      .ram_data_b(ram_data_b_1), .ram_we_b(ram_we_b_1),
      .ram_q_b(ram_q_b_1),
      .count(count_1), .full(full_1), .empty(empty_1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'hDEAD;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got=%0h exp=0", in_ready); end
         n_cmp++; if (ram_we_a !== 1'b0) begin n_err++; $display("FAIL rst_we_a got=%0h exp=0", ram_we_a); end
         n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%0h exp=0", out_valid); end
         n_cmp++; if (count !== 7'd0) begin n_err++; $display("FAIL rst_count got=%0d exp=0", count); end
         n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got=%0h exp=1", empty); end
      end
      n_cmp++; if (ram_we_b !== 1'b0 || ram_data_b !== 32'd0) begin n_err++; $display("FAIL port_b_tie got=%0h/%0h exp=0/0", ram_we_b, ram_data_b); end
      n_cmp++; if (out_data !== 32'd0) begin n_err++; $display("FAIL rst_out_data got=%0h exp=0", out_data); end
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rel_in_ready got=%0h exp=1", in_ready); end
      n_cmp++; if (ram_addr_a !== 7'd0 || ram_addr_b !== 7'd0) begin n_err++; $display("FAIL rst_ptrs got=%0d/%0d exp=0/0", ram_addr_a, ram_addr_b); end
   endtask

   task automatic test_fill_full();
      int exp;
      out_ready = 1'b0;
      for (int i = 1; i <= 49; i++) begin
         in_valid = 1'b1; in_data = 32'(i);
         #1;
         n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready word=%0d got=%0h exp=1", i, in_ready); end
         tick();
      end
      in_data = 32'h32;
      #1;
      n_cmp++; if (count !== 7'd49) begin n_err++; $display("FAIL full_count got=%0d exp=49", count); end
      n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL full_flag got=%0h exp=1", full); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready got=%0h exp=0", in_ready); end
      n_cmp++; if (ram_we_a !== 1'b0) begin n_err++; $display("FAIL full_we_a got=%0h exp=0", ram_we_a); end
      n_cmp++; if (out_data !== 32'h1) begin n_err++; $display("FAIL full_head got=%0h exp=1", out_data); end
      tick(); tick();
      n_cmp++; if (count !== 7'd49) begin n_err++; $display("FAIL full_hold_count got=%0d exp=49", count); end
      n_cmp++; if (mem0[1] !== 32'h2) begin n_err++; $display("FAIL full_no_write got=%0h exp=2", mem0[1]); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      #1;
      n_cmp++; if (out_data !== 32'h2) begin n_err++; $display("FAIL pop_next got=%0h exp=2", out_data); end
      n_cmp++; if (count !== 7'd48) begin n_err++; $display("FAIL pop_count got=%0d exp=48", count); end
      n_cmp++; if (in_ready !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL reopen got=%0h/%0h exp=1/0", in_ready, full); end
      tick();
      n_cmp++; if (count !== 7'd49) begin n_err++; $display("FAIL refill_count got=%0d exp=49", count); end
      in_valid = 1'b0; out_ready = 1'b1;
      exp = 2;
      for (int c = 0; c < 100 && exp <= 32'h32; c++) begin
         if (out_valid) begin
            n_cmp++; if (out_data !== 32'(exp)) begin n_err++; $display("FAIL drain got=%0h exp=%0h", out_data, exp); end
            exp++;
         end
         tick();
      end
      out_ready = 1'b0;
      #1;
      n_cmp++; if (exp != 32'h33) begin n_err++; $display("FAIL drain_done got=%0h exp=33", exp); end
      n_cmp++; if (empty !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty got=%0h/%0h exp=1/0", empty, out_valid); end
      n_cmp++; if (ram_addr_b !== 7'd2 || ram_addr_a !== 7'd2) begin n_err++; $display("FAIL drain_ptrs got=%0d/%0d exp=2/2", ram_addr_a, ram_addr_b); end
   endtask

   task automatic stream(input int n, input logic [31:0] base,
                         input logic [3:0] pat, output bit wrapped);
      logic [31:0] q[$];
      logic [31:0] held, exp;
      int sent, del, cyc;
      bit stalled, chk_wrap;
      sent = 0; del = 0; cyc = 0; stalled = 0; held = '0;
      wrapped = 0;
      while (del < n && cyc < 400) begin
         in_valid  = (sent < n);
         in_data   = base + 32'(sent);
         out_ready = pat[cyc % 4];
         #1;
         if (stalled) begin
            n_cmp++; if (out_data !== held || out_valid !== 1'b1) begin n_err++; $display("FAIL stall_hold got=%0h exp=%0h", out_data, held); end
         end
         stalled = out_valid && !out_ready;
         held = out_data;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               n_cmp++; n_err++; $display("FAIL stream_extra got=%0h exp=none", out_data);
            end else begin
               exp = q.pop_front();
               n_cmp++; if (out_data !== exp) begin n_err++; $display("FAIL stream_order got=%0h exp=%0h", out_data, exp); end
            end
            del++;
         end
         chk_wrap = 0;
         if (in_valid && in_ready) begin
            q.push_back(in_data);
            sent++;
            chk_wrap = (ram_addr_a == 7'd47);
         end
         tick();
         n_cmp++; if (count !== 7'(sent - del)) begin n_err++; $display("FAIL stream_count got=%0d exp=%0d", count, sent - del); end
         if (chk_wrap) begin
            wrapped = 1;
            n_cmp++; if (ram_addr_a !== 7'd0) begin n_err++; $display("FAIL wrap_addr got=%0d exp=0", ram_addr_a); end
         end
         if (cyc == 0) begin
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL latency_e got=%0h exp=0", out_valid); end
         end
         if (cyc == 1) begin
            n_cmp++; if (out_valid !== 1'b1 || out_data !== base) begin n_err++; $display("FAIL latency_e1 got=%0h/%0h exp=1/%0h", out_valid, out_data, base); end
         end
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      n_cmp++; if (del != n) begin n_err++; $display("FAIL stream_done got=%0d exp=%0d", del, n); end
   endtask

   task automatic test_wrap();
      bit w;
      stream(60, 32'h100, 4'b1111, w);
      n_cmp++; if (w != 1'b1) begin n_err++; $display("FAIL wrap_seen got=%0h exp=1", w); end
   endtask

   task automatic test_backpressure();
      bit w;
      stream(20, 32'h400, 4'b1001, w);
   endtask

   task automatic test_flush();
      logic [AW-1:0] slot;
      logic [W-1:0]  old;
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_data = 32'h200 + 32'(i);
         tick();
      end
      n_cmp++; if (count !== 7'd10) begin n_err++; $display("FAIL flush_pre_count got=%0d exp=10", count); end
      in_data = 32'h2FF; flush = 1'b1;
      #1;
      n_cmp++; if (ram_we_a !== 1'b0 || in_ready !== 1'b0) begin n_err++; $display("FAIL flush_we got=%0h/%0h exp=0/0", ram_we_a, in_ready); end
      slot = ram_addr_a;
      old = mem0[slot];
      tick();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      n_cmp++; if (count !== 7'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL flush_state got=%0d/%0h exp=0/0", count, out_valid); end
      n_cmp++; if (ram_addr_a !== 7'd0 || ram_addr_b !== 7'd0) begin n_err++; $display("FAIL flush_ptrs got=%0d/%0d exp=0/0", ram_addr_a, ram_addr_b); end
      n_cmp++; if (mem0[slot] !== old) begin n_err++; $display("FAIL flush_ram got=%0h exp=%0h", mem0[slot], old); end
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_data = 32'h300 + 32'(i);
         tick();
      end
      rst = 1'b1;
      #1;
      n_cmp++; if (ram_we_a !== 1'b0) begin n_err++; $display("FAIL rstmid_we got=%0h exp=0", ram_we_a); end
      tick();
      rst = 1'b0; in_valid = 1'b0;
      #1;
      n_cmp++; if (count !== 7'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_state got=%0d/%0h exp=0/0", count, out_valid); end
      n_cmp++; if (ram_addr_a !== 7'd0 || ram_addr_b !== 7'd0) begin n_err++; $display("FAIL rstmid_ptrs got=%0d/%0d exp=0/0", ram_addr_a, ram_addr_b); end
   endtask

   task automatic test_preload();
      logic [W-1:0] expv [6];
      int k;
      expv = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hB0};
      for (int i = 0; i < 5; i++) begin
         pl_we = 1'b1; pl_addr = 7'(i); pl_data = 32'hA0 + 32'(i);
         tick();
      end
      pl_we = 1'b0;
      rst_1 = 1'b0;
      #1;
      n_cmp++; if (count_1 !== 7'd5) begin n_err++; $display("FAIL pre_count got=%0d exp=5", count_1); end
      n_cmp++; if (ram_addr_a_1 !== 7'd5 || ram_addr_b_1 !== 7'd0) begin n_err++; $display("FAIL pre_ptrs got=%0d/%0d exp=5/0", ram_addr_a_1, ram_addr_b_1); end
      n_cmp++; if (out_valid_1 !== 1'b0 || in_ready_1 !== 1'b1) begin n_err++; $display("FAIL pre_flags got=%0h/%0h exp=0/1", out_valid_1, in_ready_1); end
      out_ready_1 = 1'b1; in_valid_1 = 1'b1; in_data_1 = 32'hB0;
      tick();
      in_valid_1 = 1'b0;
      k = 0;
      for (int c = 0; c < 20 && k < 6; c++) begin
         if (out_valid_1) begin
            n_cmp++; if (out_data_1 !== expv[k]) begin n_err++; $display("FAIL pre_order idx=%0d got=%0h exp=%0h", k, out_data_1, expv[k]); end
            k++;
         end
         tick();
      end
      n_cmp++; if (k != 6) begin n_err++; $display("FAIL pre_done got=%0d exp=6", k); end
      out_ready_1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid_1 = 1'b1; in_data_1 = 32'hC0 + 32'(i);
         tick();
      end
      rst_1 = 1'b1;
      #1;
      n_cmp++; if (ram_we_a_1 !== 1'b0) begin n_err++; $display("FAIL pre_rst_we got=%0h exp=0", ram_we_a_1); end
      tick();
      rst_1 = 1'b0; in_valid_1 = 1'b0;
      #1;
      n_cmp++; if (count_1 !== 7'd5 || out_valid_1 !== 1'b0) begin n_err++; $display("FAIL pre_rst_state got=%0d/%0h exp=5/0", count_1, out_valid_1); end
      n_cmp++; if (ram_addr_a_1 !== 7'd5 || ram_addr_b_1 !== 7'd0) begin n_err++; $display("FAIL pre_rst_ptrs got=%0d/%0d exp=5/0", ram_addr_a_1, ram_addr_b_1); end
      out_ready_1 = 1'b1;
      tick();
      n_cmp++; if (out_valid_1 !== 1'b1 || out_data_1 !== 32'hA0) begin n_err++; $display("FAIL pre_rst_head got=%0h/%0h exp=1/a0", out_valid_1, out_data_1); end
      out_ready_1 = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_data = '0;
      rst_1 = 1'b1; flush_1 = 1'b0; in_valid_1 = 1'b0;
      out_ready_1 = 1'b0; in_data_1 = '0;
      pl_we = 1'b0; pl_addr = '0; pl_data = '0;
      test_reset();
      test_fill_full();
      test_wrap();
      test_backpressure();
      test_flush();
      test_preload();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
